// File: rtl/global_cfg_broadcaster.sv
// rtl/global_cfg_broadcaster.sv - decodes vset{i}vl{i}, computes vl/vtype and splits vl across clusters
package global_cfg_broadcaster_pkg;
    typedef struct packed {
        logic       vill;
        logic       vma;
        logic       vta;
        logic [2:0] vsew;
        logic [2:0] vlmul;
    } vtype_t;

    localparam vtype_t VtypeIll = vtype_t'(9'h100);
endpackage

module global_cfg_broadcaster
    import global_cfg_broadcaster_pkg::*;
#(
    parameter int unsigned NrLanes    = 4,
    parameter int unsigned NrClusters = 4,
    parameter int unsigned VLEN       = 1024,
    parameter logic        RoundVl    = 1'b1,
    localparam int unsigned VLENB     = VLEN / 8,
    localparam int unsigned ELENB     = 8,
    localparam int unsigned VlW       = $clog2(VLEN * NrClusters) + 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    input  logic [31:0]                         insn_i,
    input  logic [63:0]                         rs1_i,
    input  logic [63:0]                         rs2_i,
    output logic [VlW-1:0]                      vl_o,
    output vtype_t                              vtype_o,
    output logic [NrClusters-1:0][VlW-1:0]      cluster_vl_o,
    output logic [NrClusters-1:0]               cfg_valid_o,
    input  logic [NrClusters-1:0]               cfg_ready_i,
    output logic                                busy_o
);

    localparam int unsigned G  = NrLanes * NrClusters;
    localparam int unsigned GW = $clog2(G);
    localparam int unsigned LW = $clog2(NrLanes);

    typedef enum logic [1:0] {IDLE, SPLIT, BCAST} state_e;

    state_e                         state_q, state_d;
    logic [VlW-1:0]                 vl_q, vl_d;
    vtype_t                         vtype_q, vtype_d;
    logic [NrClusters-1:0][VlW-1:0] cluster_vl_q, cluster_vl_d;
    logic [NrClusters-1:0]          cfg_valid_q, cfg_valid_d;

    logic                           is_cfg;
    logic                           is_vsetvli, is_vsetivli, is_vsetvl;
    logic [4:0]                     rd_f, rs1_f;
    logic [7:0]                     zimm;
    logic                           illegal;
    int                             lmul_i;
    logic [VlW-1:0]                 vlmax, uimm;
    logic [64:0]                    avl_round;
    logic [VlW-1:0]                 new_vl;
    vtype_t                         new_vtype;

    logic [VlW-1:0]                 full, rem;
    int                             share;
    logic [NrClusters-1:0][VlW-1:0] split_vl;

    always_comb begin : decode
        is_vsetvli  = (insn_i[31] == 1'b0);
        is_vsetivli = (insn_i[31:30] == 2'b11);
        is_vsetvl   = (insn_i[31:25] == 7'b1000000);
        is_cfg      = (insn_i[6:0] == 7'b1010111) && (insn_i[14:12] == 3'b111) &&
                      (is_vsetvli || is_vsetivli || is_vsetvl);
        rd_f        = insn_i[11:7];
        rs1_f       = insn_i[19:15];
        uimm        = VlW'(rs1_f);
        zimm        = is_vsetvl ? rs2_i[7:0] : insn_i[27:20];
        lmul_i      = zimm[2] ? int'(zimm[2:0]) - 8 : int'(zimm[2:0]);

        illegal     = (is_vsetvl && (rs2_i[63:8] != '0)) ||
                      ((8'd1 << zimm[5:3]) > 8'(ELENB)) ||
                      (zimm[2:0] == 3'b100) ||
                      ((3 + lmul_i) < int'(zimm[5:3]));

        vlmax = VlW'(VLENB * NrClusters) >> zimm[5:3];
        if (!zimm[2]) vlmax = vlmax << zimm[1:0];
        else          vlmax = vlmax >> (4'd8 - {1'b0, zimm[2:0]});

        // Rounding is done at 65 bits so a huge rs1 cannot wrap below vlmax.
        if (RoundVl) avl_round = ({1'b0, rs1_i} + 65'(G - 1)) & ~65'(G - 1);
        else         avl_round = {1'b0, rs1_i};

        new_vtype = vtype_t'({1'b0, zimm});
        if (illegal) begin
            new_vl    = '0;
            new_vtype = VtypeIll;
        end else if (is_vsetivli) begin
            new_vl = (uimm > vlmax) ? vlmax : uimm;
        end else if (rs1_f == 5'd0 && rd_f == 5'd0) begin
            new_vl = vl_q;
        end else if (rs1_f == 5'd0) begin
            new_vl = vlmax;
        end else begin
            new_vl = (avl_round > 65'(vlmax)) ? vlmax : avl_round[VlW-1:0];
        end
    end

    // Elements are striped lane-by-lane, so cluster c owns rem slots c*NrLanes.. of the tail.
    always_comb begin : split
        split_vl = '0;
        share    = 0;
        full     = vl_q >> GW;
        rem      = vl_q & VlW'(G - 1);
        for (int c = 0; c < int'(NrClusters); c++) begin
            share = int'(rem) - c * int'(NrLanes);
            if (share < 0) share = 0;
            if (share > int'(NrLanes)) share = int'(NrLanes);
            split_vl[c] = (full << LW) + VlW'(share);
        end
    end

    always_comb begin : fsm
        state_d      = state_q;
        vl_d         = vl_q;
        vtype_d      = vtype_q;
        cluster_vl_d = cluster_vl_q;
        cfg_valid_d  = cfg_valid_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i && is_cfg) begin
                    vl_d    = new_vl;
                    vtype_d = new_vtype;
                    state_d = SPLIT;
                end
            end
            SPLIT: begin
                cluster_vl_d = split_vl;
                cfg_valid_d  = '1;
                state_d      = BCAST;
            end
            BCAST: begin
                cfg_valid_d = cfg_valid_q & ~cfg_ready_i;
                if (cfg_valid_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            vl_q         <= '0;
            vtype_q      <= VtypeIll;
            cluster_vl_q <= '0;
            cfg_valid_q  <= '0;
        end else begin
            state_q      <= state_d;
            vl_q         <= vl_d;
            vtype_q      <= vtype_d;
            cluster_vl_q <= cluster_vl_d;
            cfg_valid_q  <= cfg_valid_d;
        end
    end

    assign req_ready_o  = (state_q == IDLE) && !rst_i;
    assign busy_o       = (state_q != IDLE);
    assign vl_o         = vl_q;
    assign vtype_o      = vtype_q;
    assign cluster_vl_o = cluster_vl_q;
    assign cfg_valid_o  = cfg_valid_q;

endmodule

// File: tb/tb_global_cfg_broadcaster.sv
// tb/tb_global_cfg_broadcaster.sv - directed and randomized checks of global_cfg_broadcaster
module tb_global_cfg_broadcaster;
    import global_cfg_broadcaster_pkg::*;

    localparam int NL   = 4;
    localparam int NC   = 4;
    localparam int VLEN = 1024;
    localparam int G    = NL * NC;
    localparam int VlW  = 13;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   req_valid = 1'b0;
    logic                   req_ready;
    logic [31:0]            insn = '0;
    logic [63:0]            rs1 = '0;
    logic [63:0]            rs2 = '0;
    logic [VlW-1:0]         vl_o;
    vtype_t                 vtype_o;
    logic [NC-1:0][VlW-1:0] cluster_vl;
    logic [NC-1:0]          cfg_valid;
    logic [NC-1:0]          cfg_ready = '0;
    logic                   busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned m_vl    = 0;
    int unsigned exp_vl;
    logic [8:0]  exp_vt;
    int unsigned exp_cl [NC];

    global_cfg_broadcaster #(
        .NrLanes(NL), .NrClusters(NC), .VLEN(VLEN), .RoundVl(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .insn_i(insn), .rs1_i(rs1), .rs2_i(rs2), .vl_o(vl_o), .vtype_o(vtype_o),
        .cluster_vl_o(cluster_vl), .cfg_valid_o(cfg_valid), .cfg_ready_i(cfg_ready),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_vli(input logic [4:0] rd, input logic [4:0] rf, input logic [7:0] z);
        return {1'b0, 3'b000, z, rf, 3'b111, rd, 7'b1010111};
    endfunction

    function automatic logic [31:0] enc_ivli(input logic [4:0] rd, input logic [4:0] uimm, input logic [7:0] z);
        return {2'b11, 2'b00, z, uimm, 3'b111, rd, 7'b1010111};
    endfunction

    function automatic logic [31:0] enc_vl(input logic [4:0] rd, input logic [4:0] rf);
        return {7'b1000000, 5'd0, rf, 3'b111, rd, 7'b1010111};
    endfunction

    function automatic logic [7:0] zv(input int sew_bits, input int lmul_code);
        logic [2:0] s;
        s = (sew_bits == 8) ? 3'd0 : (sew_bits == 16) ? 3'd1 : (sew_bits == 32) ? 3'd2 : 3'd3;
        return {2'b00, s, 3'(lmul_code)};
    endfunction

    // Reference: vlmax = VLEN*NC/SEW*LMUL as a fraction; tail elements dealt out lane by lane.
    task automatic model(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b);
        logic [7:0]  z;
        bit          bad;
        int          sew, num, den;
        int unsigned vlmax, rf, rd;
        longint unsigned r;
        rd = int'(i[11:7]);
        rf = int'(i[19:15]);
        if (i[31:25] == 7'b1000000) begin
            z   = b[7:0];
            bad = (b[63:8] != 56'd0);
        end else begin
            z   = i[27:20];
            bad = 1'b0;
        end
        sew = 8 << z[5:3];
        num = 1;
        den = 1;
        if (z[2:0] < 3'd4)      num = 1 << z[2:0];
        else if (z[2:0] > 3'd4) den = 1 << (8 - int'(z[2:0]));
        bad = bad || (z[5:3] > 3'd3) || (z[2:0] == 3'd4) || (sew * den > 64 * num);
        if (bad) begin
            exp_vl = 0;
            exp_vt = 9'h100;
        end else begin
            vlmax  = int'((VLEN * NC * num) / (sew * den));
            exp_vt = {1'b0, z};
            if (i[31:30] == 2'b11)          exp_vl = (rf < vlmax) ? rf : vlmax;
            else if (rf == 0 && rd == 0)    exp_vl = m_vl;
            else if (rf == 0)               exp_vl = vlmax;
            else if (a >= 64'(vlmax))       exp_vl = vlmax;
            else begin
                r      = ((a + 64'(G - 1)) / 64'(G)) * 64'(G);
                exp_vl = (r < 64'(vlmax)) ? int'(r) : vlmax;
            end
        end
        for (int c = 0; c < NC; c++) exp_cl[c] = 0;
        for (int e = 0; e < int'(exp_vl); e++) exp_cl[(e % G) / NL]++;
    endtask

    task automatic send(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b);
        int k;
        k = 0;
        while (!req_ready && k < 200) begin
            tick();
            k++;
        end
        check("req_ready_wait", 64'(req_ready), 64'(1));
        insn = i; rs1 = a; rs2 = b; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic post_accept(input string tag);
        int unsigned s;
        check({tag, "_vl"}, 64'(vl_o), 64'(exp_vl));
        check({tag, "_vtype"}, 64'(vtype_o), 64'(exp_vt));
        check({tag, "_busy"}, 64'(busy), 64'(1));
        tick();
        s = 0;
        for (int c = 0; c < NC; c++) begin
            check($sformatf("%s_cl%0d", tag, c), 64'(cluster_vl[c]), 64'(exp_cl[c]));
            s += int'(cluster_vl[c]);
        end
        check({tag, "_sum"}, 64'(s), 64'(vl_o));
        check({tag, "_valid"}, 64'(cfg_valid), 64'(4'hF));
        m_vl = exp_vl;
    endtask

    task automatic issue_cfg(input string tag, input logic [31:0] i, input logic [63:0] a, input logic [63:0] b);
        model(i, a, b);
        send(i, a, b);
        post_accept(tag);
    endtask

    task automatic ack_phase(input string tag, input bit rand_ack);
        logic [NC-1:0] pend;
        int k;
        pend = '1;
        k = 0;
        while (pend != '0 && k < 100) begin
            cfg_ready = rand_ack ? 4'($urandom) : 4'hF;
            tick();
            pend = pend & ~cfg_ready;
            check({tag, "_ackvalid"}, 64'(cfg_valid), 64'(pend));
            check({tag, "_ackready"}, 64'(req_ready), 64'(pend == '0));
            check({tag, "_hold"}, 64'(vl_o), 64'(exp_vl));
            k++;
        end
        cfg_ready = '0;
        check({tag, "_idle"}, 64'(busy), 64'(0));
    endtask

    task automatic run_cfg(input string tag, input logic [31:0] i, input logic [63:0] a, input logic [63:0] b, input bit rand_ack);
        issue_cfg(tag, i, a, b);
        ack_phase(tag, rand_ack);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_vl"}, 64'(vl_o), 64'(0));
        check({tag, "_vtype"}, 64'(vtype_o), 64'(9'h100));
        check({tag, "_cl"}, 64'(cluster_vl), 64'(0));
        check({tag, "_valid"}, 64'(cfg_valid), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        logic [31:0] ri;
        logic [63:0] ra, rb;
        logic [7:0]  z;
        logic [4:0]  rd, rf;
        int          kind;

        rst = 1'b1;
        repeat (3) tick();
        check_reset_vals("reset");
        check("reset_ready", 64'(req_ready), 64'(0));
        rst = 1'b0;
        #1;
        check("reset_release_ready", 64'(req_ready), 64'(1));

        run_cfg("e32m1_37", enc_vli(5'd1, 5'd5, zv(32, 0)), 64'd37, 64'd0, 1'b0);
        check("e32m1_37_abs", 64'(m_vl), 64'(48));
        run_cfg("e64m2_1000", enc_vli(5'd1, 5'd5, zv(64, 1)), 64'd1000, 64'd0, 1'b1);
        check("e64m2_abs", 64'(m_vl), 64'(128));
        run_cfg("keep_vl", enc_vli(5'd0, 5'd0, zv(16, 3)), 64'd0, 64'd0, 1'b1);
        run_cfg("vlmax", enc_vli(5'd3, 5'd0, zv(8, 7)), 64'd0, 64'd0, 1'b1);
        run_cfg("e64mf8_ill", enc_vli(5'd1, 5'd5, zv(64, 5)), 64'd40, 64'd0, 1'b0);
        run_cfg("vsetvl_hi", enc_vl(5'd1, 5'd5), 64'd40, (64'd1 << 40) | 64'(zv(8, 0)), 1'b0);
        run_cfg("huge_rs1", enc_vli(5'd1, 5'd5, zv(8, 3)), 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);

        // Cluster 2 withholds its ack while a new request waits.
        issue_cfg("ivli21", enc_ivli(5'd1, 5'd21, zv(8, 0)), 64'd0, 64'd0);
        check("ivli21_cl_abs", 64'(cluster_vl), {13'd4, 13'd4, 13'd5, 13'd8});
        cfg_ready = 4'b1011;
        tick();
        check("stall_valid", 64'(cfg_valid), 64'(4'b0100));
        cfg_ready = 4'b0000;
        insn = enc_vli(5'd1, 5'd5, zv(32, 0)); rs1 = 64'd37; rs2 = '0; req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_ready", 64'(req_ready), 64'(0));
            check("stall_valid_hold", 64'(cfg_valid), 64'(4'b0100));
            check("stall_vl", 64'(vl_o), 64'(21));
        end
        cfg_ready = 4'b0100;
        tick();
        cfg_ready = '0;
        check("stall_done_valid", 64'(cfg_valid), 64'(0));
        check("stall_done_busy", 64'(busy), 64'(0));
        check("stall_done_ready", 64'(req_ready), 64'(1));
        model(insn, rs1, rs2);
        tick();
        req_valid = 1'b0;
        post_accept("pending");
        ack_phase("pending", 1'b1);

        // Reset during BCAST and during SPLIT.
        issue_cfg("rst_b", enc_vli(5'd1, 5'd5, zv(16, 1)), 64'd77, 64'd0);
        rst = 1'b1;
        tick();
        check_reset_vals("rst_bcast");
        check("rst_bcast_ready", 64'(req_ready), 64'(0));
        rst = 1'b0;
        #1;
        check("rst_bcast_release", 64'(req_ready), 64'(1));
        m_vl = 0;
        send(enc_vli(5'd1, 5'd5, zv(8, 0)), 64'd99, 64'd0);
        rst = 1'b1;
        tick();
        check_reset_vals("rst_split");
        rst = 1'b0;
        #1;
        m_vl = 0;

        for (int t = 0; t < 60; t++) begin
            kind = int'($urandom % 4);
            rd   = ($urandom % 3 == 0) ? 5'd0 : 5'($urandom);
            rf   = ($urandom % 3 == 0) ? 5'd0 : 5'($urandom);
            z    = {2'($urandom), 3'($urandom % 5), 3'($urandom)};
            ra   = ($urandom % 4 == 0) ? {$urandom, $urandom} : 64'($urandom % 600);
            rb   = 64'(z);
            if ($urandom % 5 == 0) rb[8 + ($urandom % 56)] = 1'b1;
            if (kind == 3) begin
                ri = $urandom;
                ri[6:0] = 7'b0110011;
                send(ri, ra, rb);
                check("noncfg_busy", 64'(busy), 64'(0));
                check("noncfg_vl", 64'(vl_o), 64'(m_vl));
                check("noncfg_valid", 64'(cfg_valid), 64'(0));
            end else begin
                ri = (kind == 0) ? enc_vli(rd, rf, z) : (kind == 1) ? enc_ivli(rd, rf, z) : enc_vl(rd, rf);
                run_cfg("rnd", ri, ra, rb, 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/global_cfg_broadcaster.md
GLOBAL_CFG_BROADCASTER -- requirements
Module: global_cfg_broadcaster

Interface
REQ-001 SHALL have parameter NrLanes, default 4, lanes per cluster; power of two, at least 1.
REQ-002 SHALL have parameter NrClusters, default 4, cluster count; power of two, at least 1.
REQ-003 SHALL have parameter VLEN, default 1024, vector register bits per cluster.
REQ-004 SHALL have parameter RoundVl, default 1'b1; when set, stripmined vl is rounded up to a multiple of NrLanes*NrClusters.
REQ-005 SHALL derive local parameters: VLENB=VLEN/8, ELENB=8, VlW=$clog2(VLEN*NrClusters)+1.
REQ-006 SHALL have clk_i, input, 1, the only clock; all state updates on its rising edge.
REQ-007 SHALL have rst_i, input, 1, reset; synchronous and active-high.
REQ-008 SHALL have req_valid_i, input, 1, instruction request valid.
REQ-009 SHALL have req_ready_o, output, 1, request accepted when high together with req_valid_i.
REQ-010 SHALL have insn_i, input, 32, raw instruction.
REQ-011 SHALL have rs1_i, input, 64, scalar rs1 value.
REQ-012 SHALL have rs2_i, input, 64, scalar rs2 value.
REQ-013 SHALL have vl_o, output, VlW, current global vl.
REQ-014 SHALL have vtype_o, output, vtype_t, current vtype.
REQ-015 SHALL have cluster_vl_o, output, NrClusters x VlW, per-cluster element count.
REQ-016 SHALL have cfg_valid_o, output, NrClusters, per-cluster config-valid flag.
REQ-017 SHALL have cfg_ready_i, input, NrClusters, per-cluster config acknowledge.
REQ-018 SHALL have busy_o, output, 1, high whenever the FSM state is not IDLE.

Function
REQ-019 SHALL implement an FSM with three states: IDLE, SPLIT and BCAST.
REQ-020 SHALL drive req_ready_o = (state==IDLE) and not rst_i.
REQ-021 SHALL treat only opcode 7'b1010111 with func3 3'b111 as a config instruction.
REQ-022 SHALL accept all other instructions in IDLE, change no state, and produce no broadcast.
REQ-023 SHALL select vtype source as follows:
- vsetvli (insn[31]=0): zimm11 = insn[30:20].
- vsetivli (insn[31:30]=11): zimm10 = insn[29:20].
- vsetvl (insn[31:25]=1000000): rs2_i.
REQ-024 SHALL force vill for vsetvl when any of rs2_i[63:8] is nonzero.
REQ-025 SHALL set vtype={vill:1, others 0} and vl=0 when any of the following holds:
- vsew > 3.
- vlmul is reserved (3'b100).
- 3 + signed(vlmul) < vsew.
REQ-026 SHALL compute vlmax = (VLENB*NrClusters) >> vsew, shifted left by vlmul for vlmul 0..3 and right by 8 minus vlmul for vlmul 5..7.
REQ-027 SHALL compute vl for vsetivli as min(uimm5, vlmax), with no rounding.
REQ-028 SHALL compute vl for vsetvl/vsetvli with rs1 field 0 and rd field 0 as the previous vl.
REQ-029 SHALL compute vl for vsetvl/vsetvli with rs1 field 0 and rd field nonzero as vlmax.
REQ-030 SHALL compute vl otherwise as min(R, vlmax), where R is rs1_i rounded up to a multiple of NrLanes*NrClusters when RoundVl=1, else rs1_i; the rounding and comparison are evaluated at 65 bits, with no truncation before the min.
REQ-031 SHALL capture a config instruction on acceptance in cycle T, registering vl_o and vtype_o at T+1 and entering SPLIT.
REQ-032 SHALL compute the split in SPLIT, with G=NrLanes*NrClusters, full=vl/G, rem=vl%G.
REQ-033 SHALL set cluster_vl[c] = full*NrLanes + clamp(rem - c*NrLanes, 0, NrLanes).
REQ-034 SHALL register cluster_vl_o and set all cfg_valid_o bits at T+2, then enter BCAST.
REQ-035 SHALL broadcast with vill set (all cluster_vl 0) exactly like a legal config.
REQ-036 SHALL, in BCAST, clear cfg_valid_o[c] on the cycle after cfg_valid_o[c] & cfg_ready_i[c].
REQ-037 SHALL ignore cfg_ready_i[c] whenever cfg_valid_o[c]=0.
REQ-038 SHALL hold cluster_vl_o, vl_o and vtype_o stable during BCAST.
REQ-039 SHALL return to IDLE on the cycle after the last outstanding acknowledge; simultaneous acks from all clusters complete in one cycle.
REQ-040 SHALL guarantee the sum over c of cluster_vl_o equals vl_o at all times outside SPLIT.

Reset
REQ-041 SHALL reset synchronously when rst_i=1 at a clock edge:
- state=IDLE, vl_o=0, vtype_o={vill:1, others 0}.
- cluster_vl_o=0, cfg_valid_o=0, busy_o=0.
REQ-042 SHALL hold req_ready_o=0 while rst_i=1.
REQ-043 SHALL, on reset asserted in SPLIT or BCAST, drop pending acknowledges and the in-flight config without partial update.

Verification
All scenarios use NrLanes=4, NrClusters=4, VLEN=1024, RoundVl=1.
REQ-044 SHALL cover vsetvli rd=1, rs1=5, rs1_i=37, e32 m1 -> vl_o=48, cluster_vl_o={12,12,12,12}, cfg_valid_o=4'b1111 at T+2.
REQ-045 SHALL cover vsetivli uimm5=21, e8 m1 -> vl_o=21, cluster_vl_o[0..3]={8,5,4,4}.
REQ-046 SHALL cover vsetvli rs1_i=1000, e64 m2 -> vlmax=128, vl_o=128, each cluster 32.
REQ-047 SHALL cover e64 mf8, and separately vsetvl with rs2_i[40]=1 -> vtype_o.vill=1, vl_o=0, all cluster_vl_o=0, broadcast still issued.
REQ-048 SHALL cover cfg_ready_i[2] held low 3 cycles in BCAST -> bits 0, 1 and 3 clear after their acks, req_ready_o=0 and a pending req_valid_i is held until cluster 2 acks, then IDLE.
REQ-049 SHALL cover rst_i pulsed during BCAST -> next cycle all outputs at their reset values and req_ready_o=1 after rst_i deasserts.
